// File: rtl/johnson_pkg.sv
// Shared Johnson-counter helpers: phase<->code mapping, legality check, direction codes.
// Functions work on a fixed maximum width; callers pass their ring width and truncate.
package johnson_pkg;

    localparam int unsigned JMAX = 64;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_BAD_LOAD,
        ACT_FIX,
        ACT_STEP
    } act_e;

    // Phases 1..n fill ones from the top; phases n+1..2n-1 drain them from the top.
    function automatic logic [JMAX-1:0] johnson_encode(int unsigned n, int unsigned ph);
        logic [JMAX-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < JMAX; i++) begin
            if (i < n) begin
                if (ph <= n) code[i] = (i >= n - ph);
                else         code[i] = (i < 2 * n - ph);
            end
        end
        return code;
    endfunction

    function automatic logic johnson_legal(logic [JMAX-1:0] q, int unsigned n);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i < JMAX - 1; i++) begin
            if ((i + 1 < n) && (q[i] != q[i+1])) edges++;
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_counter_param_if.sv
// Control and status bundle of the Johnson counter; master drives control, slave is the counter.
interface johnson_counter_param_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(2 * N)
);
    logic            en;
    logic            dir;
    logic            load;
    logic [PW-1:0]   load_phase;
    logic [N-1:0]    q;
    logic [PW-1:0]   phase;
    logic [2*N-1:0]  phase_oh;
    logic            wrap;
    logic            err;

    modport master (
        output en, dir, load, load_phase,
        input  q, phase, phase_oh, wrap, err
    );

    modport slave (
        input  en, dir, load, load_phase,
        output q, phase, phase_oh, wrap, err
    );
endinterface

// File: rtl/johnson_phase_decode.sv
// Combinational binary phase index to one-hot decoder, shared by the sequence generators.
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter int unsigned STATES = 8,
    parameter int unsigned PW     = $clog2(STATES)
) (
    input  logic [PW-1:0]     phase_i,
    output logic [STATES-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < STATES; i++) begin
            if (phase_i == PW'(i)) onehot_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with enable, direction, phase load, self-correction,
// registered binary phase, one-hot phase, wrap and error pulses.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(2 * N)
) (
    input logic                     clk,
    input logic                     reset,
    johnson_counter_param_if.slave  bus
);

    localparam int unsigned STATES = 2 * N;

    if (N < 2) begin : g_bad_width
        $error("johnson_counter_param: N must be at least 2");
    end

    logic [N-1:0]  q_q, q_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;

    act_e          act;
    logic          load_in_range;
    logic          q_legal;
    logic [PW-1:0] phase_fwd, phase_rev;

    assign load_in_range = (32'(bus.load_phase) < STATES);
    assign q_legal       = johnson_legal(JMAX'(q_q), N);

    assign phase_fwd = (phase_q == PW'(STATES - 1)) ? '0 : phase_q + PW'(1);
    assign phase_rev = (phase_q == '0) ? PW'(STATES - 1) : phase_q - PW'(1);

    always_comb begin
        if (bus.load)       act = load_in_range ? ACT_LOAD : ACT_BAD_LOAD;
        else if (!q_legal)  act = ACT_FIX;
        else if (bus.en)    act = ACT_STEP;
        else                act = ACT_HOLD;
    end

    always_comb begin
        q_d     = q_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (act)
            ACT_LOAD: begin
                q_d     = N'(johnson_encode(N, 32'(bus.load_phase)));
                phase_d = bus.load_phase;
            end
            ACT_BAD_LOAD: begin
                err_d = 1'b1;
            end
            ACT_FIX: begin
                q_d     = '0;
                phase_d = '0;
                err_d   = 1'b1;
            end
            ACT_STEP: begin
                if (bus.dir == DIR_REV) begin
                    q_d     = {q_q[N-2:0], ~q_q[N-1]};
                    phase_d = phase_rev;
                end else begin
                    q_d     = {~q_q[0], q_q[N-1:1]};
                    phase_d = phase_fwd;
                end
                wrap_d = (phase_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.phase = phase_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

    johnson_phase_decode #(
        .STATES (STATES),
        .PW     (PW)
    ) u_decode (
        .phase_i  (phase_q),
        .onehot_o (bus.phase_oh)
    );

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param (N=4 and N=3) against an arithmetic phase model.
module tb_johnson_counter_param;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    johnson_counter_param_if #(.N(4), .PW(3)) b4 ();
    johnson_counter_param_if #(.N(3), .PW(3)) b3 ();

    johnson_counter_param #(.N(4)) dut4 (.clk(clk), .reset(rst_n), .bus(b4.slave));
    johnson_counter_param #(.N(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3.slave));

    typedef struct packed {
        logic [31:0] ph;
        logic        w;
        logic        e;
    } mres_t;

    // Code for phase k: k ones from the top for k<=n, else (2n-k) ones at the bottom.
    function automatic logic [7:0] m_code(int unsigned n, int unsigned k);
        int unsigned mask;
        mask = (1 << n) - 1;
        if (k <= n) return 8'(mask ^ ((1 << (n - k)) - 1));
        return 8'((1 << (2 * n - k)) - 1);
    endfunction

    function automatic mres_t m_next(int unsigned n, int unsigned ph, logic en, logic dir,
                                     logic ld, int unsigned lp);
        mres_t r;
        r.ph = ph; r.w = 1'b0; r.e = 1'b0;
        if (ld) begin
            if (lp < 2 * n) r.ph = lp;
            else            r.e  = 1'b1;
        end else if (en) begin
            r.ph = dir ? (ph + 2 * n - 1) % (2 * n) : (ph + 1) % (2 * n);
            r.w  = (r.ph == 0);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        b4.en = 0; b4.dir = 0; b4.load = 0; b4.load_phase = '0;
        b3.en = 0; b3.dir = 0; b3.load = 0; b3.load_phase = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (b4.q !== 4'b0000) begin fails++; $display("FAIL reset_q4 got %b exp 0000", b4.q); end
        tests++; if (b4.phase !== 3'd0) begin fails++; $display("FAIL reset_phase4 got %0d exp 0", b4.phase); end
        tests++; if (b4.phase_oh !== 8'h01) begin fails++; $display("FAIL reset_oh4 got %b exp 00000001", b4.phase_oh); end
        tests++; if ({b4.wrap, b4.err} !== 2'b00) begin fails++; $display("FAIL reset_flags4 got %b exp 00", {b4.wrap, b4.err}); end
        tests++; if (b3.q !== 3'b000) begin fails++; $display("FAIL reset_q3 got %b exp 000", b3.q); end
        tests++; if (b3.phase_oh !== 6'h01) begin fails++; $display("FAIL reset_oh3 got %b exp 000001", b3.phase_oh); end
    endtask

    task automatic test_forward();
        logic [3:0] exp_q;
        int unsigned k;
        do_reset();
        b4.en = 1'b1; b4.dir = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            k = i % 8;
            exp_q = 4'(m_code(4, k));
            tests++; if (b4.q !== exp_q) begin fails++; $display("FAIL fwd_q step %0d got %b exp %b", i, b4.q, exp_q); end
            tests++; if (b4.phase !== 3'(k)) begin fails++; $display("FAIL fwd_phase step %0d got %0d exp %0d", i, b4.phase, k); end
            tests++; if (b4.wrap !== (k == 0)) begin fails++; $display("FAIL fwd_wrap step %0d got %b exp %b", i, b4.wrap, (k == 0)); end
            tests++; if (b4.phase_oh !== (8'd1 << k)) begin fails++; $display("FAIL fwd_oh step %0d got %b exp %b", i, b4.phase_oh, (8'd1 << k)); end
        end
        b4.en = 1'b0;
    endtask

    task automatic test_reverse();
        logic [3:0] exp_q [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000};
        logic [2:0] exp_p [4] = '{3'd1, 3'd0, 3'd7, 3'd0};
        b4.load = 1'b1; b4.load_phase = 3'd2; b4.en = 1'b0;
        tick();
        tests++; if (b4.q !== 4'b1100) begin fails++; $display("FAIL rev_load_q got %b exp 1100", b4.q); end
        b4.load = 1'b0; b4.en = 1'b1; b4.dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) b4.dir = 1'b0;
            tick();
            tests++; if (b4.q !== exp_q[i]) begin fails++; $display("FAIL rev_q step %0d got %b exp %b", i, b4.q, exp_q[i]); end
            tests++; if (b4.phase !== exp_p[i]) begin fails++; $display("FAIL rev_phase step %0d got %0d exp %0d", i, b4.phase, exp_p[i]); end
            tests++; if (b4.wrap !== (exp_p[i] == 3'd0)) begin fails++; $display("FAIL rev_wrap step %0d got %b exp %b", i, b4.wrap, (exp_p[i] == 3'd0)); end
        end
        b4.en = 1'b0;
    endtask

    task automatic test_load();
        b4.load = 1'b1; b4.load_phase = 3'd5; b4.en = 1'b1; b4.dir = 1'b0;
        tick();
        tests++; if (b4.q !== 4'b0111) begin fails++; $display("FAIL load_q got %b exp 0111", b4.q); end
        tests++; if (b4.phase !== 3'd5) begin fails++; $display("FAIL load_phase got %0d exp 5", b4.phase); end
        tests++; if ({b4.wrap, b4.err} !== 2'b00) begin fails++; $display("FAIL load_flags got %b exp 00", {b4.wrap, b4.err}); end
        b4.load = 1'b0; b4.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (b4.q !== 4'b0111) begin fails++; $display("FAIL hold_q cyc %0d got %b exp 0111", i, b4.q); end
        end
    endtask

    task automatic test_bad_load();
        b3.load = 1'b1; b3.load_phase = 3'd2;
        tick();
        tests++; if (b3.q !== 3'b110) begin fails++; $display("FAIL bad_pre_q got %b exp 110", b3.q); end
        b3.load_phase = 3'd6; b3.en = 1'b1;
        tick();
        tests++; if (b3.q !== 3'b110) begin fails++; $display("FAIL bad_q got %b exp 110", b3.q); end
        tests++; if (b3.phase !== 3'd2) begin fails++; $display("FAIL bad_phase got %0d exp 2", b3.phase); end
        tests++; if (b3.err !== 1'b1) begin fails++; $display("FAIL bad_err got %b exp 1", b3.err); end
        b3.load = 1'b0; b3.en = 1'b0;
        tick();
        tests++; if (b3.err !== 1'b0) begin fails++; $display("FAIL bad_err_clear got %b exp 0", b3.err); end
        b3.load = 1'b1; b3.load_phase = 3'd4;
        tick();
        tests++; if (b3.q !== 3'b011) begin fails++; $display("FAIL load4_q got %b exp 011", b3.q); end
        tests++; if (b3.phase !== 3'd4) begin fails++; $display("FAIL load4_phase got %0d exp 4", b3.phase); end
        tests++; if (b3.err !== 1'b0) begin fails++; $display("FAIL load4_err got %b exp 0", b3.err); end
        b3.load = 1'b0;
    endtask

    task automatic test_illegal();
        b4.load = 1'b1; b4.load_phase = 3'd3; b4.en = 1'b0;
        tick();
        b4.load = 1'b0;
        @(negedge clk);
        force dut4.q_q = 4'b1010;
        #1;
        release dut4.q_q;
        b4.en = 1'b1; b4.dir = 1'b0;
        tick();
        tests++; if (b4.q !== 4'b0000) begin fails++; $display("FAIL fix_q got %b exp 0000", b4.q); end
        tests++; if (b4.phase !== 3'd0) begin fails++; $display("FAIL fix_phase got %0d exp 0", b4.phase); end
        tests++; if ({b4.wrap, b4.err} !== 2'b01) begin fails++; $display("FAIL fix_flags got %b exp 01", {b4.wrap, b4.err}); end
        tick();
        tests++; if (b4.q !== 4'b1000) begin fails++; $display("FAIL fix_resume_q got %b exp 1000", b4.q); end
        tests++; if (b4.err !== 1'b0) begin fails++; $display("FAIL fix_resume_err got %b exp 0", b4.err); end
        b4.en = 1'b0;
    endtask

    task automatic test_async_reset();
        b4.load = 1'b1; b4.load_phase = 3'd6;
        tick();
        b4.load = 1'b0; b4.en = 1'b1; b4.dir = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (b4.q !== 4'b0000) begin fails++; $display("FAIL arst_q got %b exp 0000", b4.q); end
        tests++; if (b4.phase !== 3'd0) begin fails++; $display("FAIL arst_phase got %0d exp 0", b4.phase); end
        tests++; if ({b4.wrap, b4.err} !== 2'b00) begin fails++; $display("FAIL arst_flags got %b exp 00", {b4.wrap, b4.err}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++; if (b4.q !== 4'b1000) begin fails++; $display("FAIL arst_first_q got %b exp 1000", b4.q); end
        tests++; if (b4.phase !== 3'd1) begin fails++; $display("FAIL arst_first_phase got %0d exp 1", b4.phase); end
        b4.en = 1'b0;
    endtask

    task automatic test_random4();
        int unsigned mp = 0;
        mres_t r;
        logic [3:0] eq;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            b4.en = 1'($urandom_range(0, 1));
            b4.dir = 1'($urandom_range(0, 1));
            b4.load = ($urandom_range(0, 7) == 0);
            b4.load_phase = 3'($urandom_range(0, 7));
            r = m_next(4, mp, b4.en, b4.dir, b4.load, 32'(b4.load_phase));
            tick();
            mp = r.ph;
            eq = 4'(m_code(4, mp));
            tests++; if (b4.q !== eq) begin fails++; $display("FAIL rnd4_q cyc %0d got %b exp %b", c, b4.q, eq); end
            tests++; if (b4.phase !== 3'(mp)) begin fails++; $display("FAIL rnd4_phase cyc %0d got %0d exp %0d", c, b4.phase, mp); end
            tests++; if (b4.phase_oh !== (8'd1 << mp)) begin fails++; $display("FAIL rnd4_oh cyc %0d got %b exp %b", c, b4.phase_oh, (8'd1 << mp)); end
            tests++; if ({b4.wrap, b4.err} !== {r.w, r.e}) begin fails++; $display("FAIL rnd4_flags cyc %0d got %b exp %b", c, {b4.wrap, b4.err}, {r.w, r.e}); end
        end
        b4.en = 1'b0; b4.load = 1'b0;
    endtask

    task automatic test_random3();
        int unsigned mp = 0;
        mres_t r;
        logic [2:0] eq;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            b3.en = 1'($urandom_range(0, 1));
            b3.dir = 1'($urandom_range(0, 1));
            b3.load = ($urandom_range(0, 3) == 0);
            b3.load_phase = 3'($urandom_range(0, 7));
            r = m_next(3, mp, b3.en, b3.dir, b3.load, 32'(b3.load_phase));
            tick();
            mp = r.ph;
            eq = 3'(m_code(3, mp));
            tests++; if (b3.q !== eq) begin fails++; $display("FAIL rnd3_q cyc %0d got %b exp %b", c, b3.q, eq); end
            tests++; if (b3.phase !== 3'(mp)) begin fails++; $display("FAIL rnd3_phase cyc %0d got %0d exp %0d", c, b3.phase, mp); end
            tests++; if (b3.phase_oh !== (6'd1 << mp)) begin fails++; $display("FAIL rnd3_oh cyc %0d got %b exp %b", c, b3.phase_oh, (6'd1 << mp)); end
            tests++; if ({b3.wrap, b3.err} !== {r.w, r.e}) begin fails++; $display("FAIL rnd3_flags cyc %0d got %b exp %b", c, {b3.wrap, b3.err}, {r.w, r.e}); end
        end
        b3.en = 1'b0; b3.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_load();
        test_bad_load();
        test_illegal();
        test_async_reset();
        test_random4();
        test_random3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
